// File: rtl/lp_plate_seq.sv
// License-plate recognition sequencer: runs the labeling engine, collects
// classifier characters into a small buffer, then streams them out in order.
module lp_plate_seq #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned PIX_W     = 8,
  parameter int unsigned CH_W      = 6,
  parameter int unsigned MAX_CHARS = 8,
  parameter int unsigned TO_CYCLES = 65535
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [PIX_W-1:0]             th_low,
  input  logic [PIX_W-1:0]             th_high,
  output logic                         ccl_start,
  output logic [PIX_W-1:0]             ccl_th_low,
  output logic [PIX_W-1:0]             ccl_th_high,
  input  logic                         ccl_done,
  input  logic [ADDR_W-1:0]            ccl_addr,
  output logic                         cls_start,
  input  logic [ADDR_W-1:0]            cls_addr,
  input  logic                         cls_valid,
  input  logic [CH_W-1:0]              cls_char,
  input  logic                         cls_ok,
  input  logic                         cls_done,
  output logic [ADDR_W-1:0]            pix_addr,
  output logic [CH_W-1:0]              ch_data,
  output logic                         ch_valid,
  output logic                         ch_last,
  input  logic                         ch_ready,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(MAX_CHARS):0]   char_cnt,
  output logic [7:0]                   rej_cnt,
  output logic                         err_timeout,
  output logic                         err_overflow
);

  localparam int unsigned IDX_W = $clog2(MAX_CHARS);
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam int unsigned TO_W  = $clog2(TO_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CCL,
    S_CLS,
    S_DRAIN,
    S_FIN
  } state_t;

  state_t            state;
  logic [TO_W-1:0]   to_cnt;
  logic [IDX_W-1:0]  rd_ptr;
  logic [CH_W-1:0]   buf_mem [MAX_CHARS];

  logic              full_c;
  logic              wr_en_c;
  logic [CNT_W-1:0]  cnt_nxt_c;
  logic [CH_W-1:0]   first_c;
  logic              to_hit_c;
  logic              cls_end_c;
  logic [IDX_W-1:0]  rd_nxt_c;

  // Buffer write decision and drain helpers shared by the sequencer.
  always_comb begin
    full_c    = (char_cnt == CNT_W'(MAX_CHARS));
    wr_en_c   = (state == S_CLS) && cls_valid && cls_ok && !full_c;
    cnt_nxt_c = wr_en_c ? (char_cnt + CNT_W'(1)) : char_cnt;
    // A character arriving together with cls_done into an empty buffer is
    // not in the memory yet, so forward it directly as the first beat.
    first_c   = (char_cnt == '0) ? cls_char : buf_mem[0];
    to_hit_c  = (to_cnt == TO_W'(1));
    cls_end_c = cls_done || (!cls_valid && to_hit_c);
    rd_nxt_c  = rd_ptr + IDX_W'(1);
  end

  // Shared image memory address follows whichever engine owns the phase.
  always_comb begin
    pix_addr = '0;
    case (state)
      S_CCL:   pix_addr = ccl_addr;
      S_CLS:   pix_addr = cls_addr;
      default: pix_addr = '0;
    endcase
  end

  // Character storage; validity is tracked by char_cnt, so no reset needed.
  always_ff @(posedge clk) begin
    if (wr_en_c) buf_mem[char_cnt[IDX_W-1:0]] <= cls_char;
  end

  // Frame sequencer with registered pulses, counters and stream outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      to_cnt       <= '0;
      rd_ptr       <= '0;
      ccl_start    <= 1'b0;
      cls_start    <= 1'b0;
      ccl_th_low   <= '0;
      ccl_th_high  <= '0;
      ch_data      <= '0;
      ch_valid     <= 1'b0;
      ch_last      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      char_cnt     <= '0;
      rej_cnt      <= '0;
      err_timeout  <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      ccl_start <= 1'b0;
      cls_start <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            ccl_th_low   <= th_low;
            ccl_th_high  <= th_high;
            char_cnt     <= '0;
            rej_cnt      <= '0;
            err_timeout  <= 1'b0;
            err_overflow <= 1'b0;
            ccl_start    <= 1'b1;
            busy         <= 1'b1;
            to_cnt       <= TO_W'(TO_CYCLES);
            state        <= S_CCL;
          end
        end
        S_CCL: begin
          if (ccl_done) begin
            cls_start <= 1'b1;
            to_cnt    <= TO_W'(TO_CYCLES);
            state     <= S_CLS;
          end else if (to_hit_c) begin
            // Buffer is always empty during labeling, so skip straight to FIN.
            err_timeout <= 1'b1;
            done        <= 1'b1;
            state       <= S_FIN;
          end else begin
            to_cnt <= to_cnt - TO_W'(1);
          end
        end
        S_CLS: begin
          if (cls_valid) begin
            if (cls_ok) begin
              if (full_c) err_overflow <= 1'b1;
              else        char_cnt     <= cnt_nxt_c;
            end else if (rej_cnt != 8'hFF) begin
              rej_cnt <= rej_cnt + 8'd1;
            end
          end
          if (cls_end_c) begin
            if (!cls_done) err_timeout <= 1'b1;
            if (cnt_nxt_c != '0) begin
              ch_valid <= 1'b1;
              ch_data  <= first_c;
              ch_last  <= (cnt_nxt_c == CNT_W'(1));
              rd_ptr   <= '0;
              state    <= S_DRAIN;
            end else begin
              done  <= 1'b1;
              state <= S_FIN;
            end
          end else if (cls_valid) begin
            to_cnt <= TO_W'(TO_CYCLES);
          end else begin
            to_cnt <= to_cnt - TO_W'(1);
          end
        end
        S_DRAIN: begin
          if (ch_ready) begin
            if (ch_last) begin
              ch_valid <= 1'b0;
              ch_last  <= 1'b0;
              ch_data  <= '0;
              done     <= 1'b1;
              state    <= S_FIN;
            end else begin
              rd_ptr  <= rd_nxt_c;
              ch_data <= buf_mem[rd_nxt_c];
              ch_last <= ((CNT_W'(rd_ptr) + CNT_W'(2)) == char_cnt);
            end
          end
        end
        S_FIN: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lp_plate_seq.sv
// Bench for lp_plate_seq: randomized frames checked every cycle against a
// queue-based frame model, plus literal expectations for the named scenarios.
module tb_lp_plate_seq;

  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned PIX_W     = 8;
  localparam int unsigned CH_W      = 6;
  localparam int unsigned MAX_CHARS = 8;
  localparam int unsigned TO_CYCLES = 20;
  localparam int P_IDLE = 0, P_CCL = 1, P_CLS = 2, P_DRAIN = 3, P_FIN = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [PIX_W-1:0]  th_low = '0, th_high = '0;
  logic              ccl_start;
  logic [PIX_W-1:0]  ccl_th_low, ccl_th_high;
  logic              ccl_done = 1'b0;
  logic [ADDR_W-1:0] ccl_addr = '0;
  logic              cls_start;
  logic [ADDR_W-1:0] cls_addr = '0;
  logic              cls_valid = 1'b0;
  logic [CH_W-1:0]   cls_char = '0;
  logic              cls_ok = 1'b0;
  logic              cls_done = 1'b0;
  logic [ADDR_W-1:0] pix_addr;
  logic [CH_W-1:0]   ch_data;
  logic              ch_valid, ch_last;
  logic              ch_ready = 1'b0;
  logic              busy, done;
  logic [3:0]        char_cnt;
  logic [7:0]        rej_cnt;
  logic              err_timeout, err_overflow;

  lp_plate_seq #(
    .ADDR_W(ADDR_W), .PIX_W(PIX_W), .CH_W(CH_W),
    .MAX_CHARS(MAX_CHARS), .TO_CYCLES(TO_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .th_low(th_low), .th_high(th_high),
    .ccl_start(ccl_start), .ccl_th_low(ccl_th_low), .ccl_th_high(ccl_th_high),
    .ccl_done(ccl_done), .ccl_addr(ccl_addr),
    .cls_start(cls_start), .cls_addr(cls_addr), .cls_valid(cls_valid),
    .cls_char(cls_char), .cls_ok(cls_ok), .cls_done(cls_done),
    .pix_addr(pix_addr), .ch_data(ch_data), .ch_valid(ch_valid),
    .ch_last(ch_last), .ch_ready(ch_ready),
    .busy(busy), .done(done), .char_cnt(char_cnt), .rej_cnt(rej_cnt),
    .err_timeout(err_timeout), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int cyc = 0, start_cyc = 0, done_cyc = 0;
  int n_done = 0, n_ccl = 0, n_cls = 0;
  int rdy_mode = 0;
  logic [CH_W-1:0] sent_ok[$];
  logic [CH_W-1:0] out_q[$];

  // Frame model state
  int              m_phase, m_sent, m_rej, m_t;
  bit              m_ovf, m_tmo, m_ccl_p, m_cls_p;
  logic [PIX_W-1:0] m_thl, m_thh;
  logic [CH_W-1:0] m_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic m_reset();
    m_phase = P_IDLE; m_sent = 0; m_rej = 0; m_t = 0;
    m_ovf = 0; m_tmo = 0; m_ccl_p = 0; m_cls_p = 0;
    m_thl = '0; m_thh = '0; m_q.delete();
  endtask

  // One clock of the frame rules, applied to the inputs seen at this edge.
  task automatic m_step();
    bit p1 = 0, p2 = 0;
    case (m_phase)
      P_IDLE: if (start) begin
        m_thl = th_low; m_thh = th_high; m_q.delete();
        m_rej = 0; m_ovf = 0; m_tmo = 0; m_t = 0; m_sent = 0;
        m_phase = P_CCL; p1 = 1;
      end
      P_CCL: begin
        if (ccl_done) begin m_phase = P_CLS; p2 = 1; m_t = 0; end
        else begin
          m_t++;
          if (m_t >= int'(TO_CYCLES)) begin m_tmo = 1; m_phase = P_FIN; end
        end
      end
      P_CLS: begin
        if (cls_valid) begin
          if (cls_ok) begin
            if (m_q.size() < int'(MAX_CHARS)) m_q.push_back(cls_char);
            else m_ovf = 1;
          end else if (m_rej < 255) m_rej++;
        end
        if (cls_done) m_phase = (m_q.size() > 0) ? P_DRAIN : P_FIN;
        else if (cls_valid) m_t = 0;
        else begin
          m_t++;
          if (m_t >= int'(TO_CYCLES)) begin
            m_tmo = 1;
            m_phase = (m_q.size() > 0) ? P_DRAIN : P_FIN;
          end
        end
      end
      P_DRAIN: if (ch_ready) begin
        m_sent++;
        if (m_sent == m_q.size()) m_phase = P_FIN;
      end
      default: m_phase = P_IDLE;
    endcase
    m_ccl_p = p1; m_cls_p = p2;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) m_reset();
      else m_step();
    end
  end

  // Per-cycle comparison of every output against the model.
  bit              stall_prev = 0;
  logic [CH_W-1:0] prev_data = '0;
  initial begin
    forever begin
      logic [CH_W-1:0]   ed;
      logic              ev, el;
      logic [ADDR_W-1:0] ep;
      @(negedge clk);
      ev = (m_phase == P_DRAIN);
      ed = ev ? m_q[m_sent] : '0;
      el = ev && (m_sent == m_q.size() - 1);
      ep = (m_phase == P_CCL) ? ccl_addr : (m_phase == P_CLS) ? cls_addr : '0;
      chk("busy",      32'(busy),         32'(m_phase != P_IDLE));
      chk("done",      32'(done),         32'(m_phase == P_FIN));
      chk("ccl_start", 32'(ccl_start),    32'(m_ccl_p));
      chk("cls_start", 32'(cls_start),    32'(m_cls_p));
      chk("th_low",    32'(ccl_th_low),   32'(m_thl));
      chk("th_high",   32'(ccl_th_high),  32'(m_thh));
      chk("pix_addr",  32'(pix_addr),     32'(ep));
      chk("ch_valid",  32'(ch_valid),     32'(ev));
      chk("ch_data",   32'(ch_data),      32'(ed));
      chk("ch_last",   32'(ch_last),      32'(el));
      chk("char_cnt",  32'(char_cnt),     32'(m_q.size()));
      chk("rej_cnt",   32'(rej_cnt),      32'(m_rej));
      chk("err_to",    32'(err_timeout),  32'(m_tmo));
      chk("err_ovf",   32'(err_overflow), 32'(m_ovf));
      if (rst && stall_prev) chk("hold_data", 32'({ch_valid, ch_data}), 32'({1'b1, prev_data}));
      stall_prev = rst && ch_valid && !ch_ready;
      prev_data  = ch_data;
      if (rst && ch_valid && ch_ready) out_q.push_back(ch_data);
      if (done) begin n_done++; done_cyc = cyc; end
      if (ccl_start) n_ccl++;
      if (cls_start) n_cls++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
    ccl_addr = ADDR_W'($urandom);
    cls_addr = ADDR_W'($urandom);
    case (rdy_mode)
      0: ch_ready = 1'b1;
      1: ch_ready = ~ch_ready;
      2: ch_ready = 1'($urandom % 2);
      default: ch_ready = 1'b0;
    endcase
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin tick(); k++; end
    chk("idle_within_budget", 32'(busy), 32'(0));
  endtask

  // ccl_lat=0 means the labeling engine never finishes.
  task automatic do_frame(input logic [PIX_W-1:0] tl, input logic [PIX_W-1:0] th,
                          input int ccl_lat, input int n_ok, input int n_rej,
                          input int max_gap, input bit send_done, input bit merge_done,
                          input int rmode, input bit noise_start, input bit wait_end);
    int  ok_left = n_ok, rej_left = n_rej;
    bit  ok, merged = 0;
    sent_ok.delete(); out_q.delete();
    rdy_mode = rmode;
    th_low = tl; th_high = th; start = 1'b1;
    tick();
    start_cyc = cyc;
    start = noise_start;
    if (ccl_lat > 0) begin
      repeat (ccl_lat - 1) tick();
      ccl_done = 1'b1; tick(); ccl_done = 1'b0;
      while (ok_left + rej_left > 0) begin
        repeat ($urandom_range(max_gap, 0)) tick();
        ok = (rej_left == 0) || (ok_left > 0 && ($urandom % 2) == 1);
        cls_valid = 1'b1; cls_ok = ok; cls_char = CH_W'($urandom);
        if (ok) begin sent_ok.push_back(cls_char); ok_left--; end
        else rej_left--;
        if (ok_left + rej_left == 0 && merge_done && send_done) begin
          cls_done = 1'b1; merged = 1;
        end
        tick();
        cls_valid = 1'b0; cls_ok = 1'b0; cls_done = 1'b0;
      end
      if (send_done && !merged) begin
        repeat ($urandom_range(max_gap, 0)) tick();
        cls_done = 1'b1; tick(); cls_done = 1'b0;
      end
    end
    start = 1'b0;
    if (wait_end) wait_idle(400);
  endtask

  task automatic chk_order(input string nm, input int n);
    chk({nm, "_beats"}, 32'(out_q.size()), 32'(n));
    for (int i = 0; i < n && i < out_q.size(); i++)
      chk({nm, "_order"}, 32'(out_q[i]), 32'(sent_ok[i]));
  endtask

  initial begin
    int d0, c0;
    repeat (3) tick();
    // Reset values
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_pix", 32'(pix_addr), 32'(0));
    chk("rst_cnt", 32'(char_cnt), 32'(0));
    @(posedge clk); #1 rst = 1'b1;
    tick();

    // Nominal: 7 ordered characters
    d0 = n_done;
    do_frame(8'd40, 8'd255, 10, 7, 0, 3, 1, 0, 0, 0, 1);
    chk_order("nom", 7);
    chk("nom_cnt", 32'(char_cnt), 32'(7));
    chk("nom_thl", 32'(ccl_th_low), 32'(40));
    chk("nom_thh", 32'(ccl_th_high), 32'(255));
    chk("nom_done", 32'(n_done - d0), 32'(1));
    chk("nom_errs", 32'({err_timeout, err_overflow}), 32'(0));

    // Backpressure with ready toggling
    do_frame(8'd10, 8'd200, 4, 6, 0, 2, 1, 0, 1, 0, 1);
    chk_order("bp", 6);

    // Overflow and rejects
    do_frame(8'd1, 8'd2, 3, 10, 3, 2, 1, 0, 0, 0, 1);
    chk_order("ovf", 8);
    chk("ovf_cnt", 32'(char_cnt), 32'(8));
    chk("ovf_rej", 32'(rej_cnt), 32'(3));
    chk("ovf_flag", 32'(err_overflow), 32'(1));

    // Labeling timeout: done lands 20 cycles after the start edge
    d0 = n_done; c0 = n_cls;
    do_frame(8'd5, 8'd6, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("to_flag", 32'(err_timeout), 32'(1));
    chk("to_latency", 32'(done_cyc - start_cyc), 32'(TO_CYCLES));
    chk("to_no_cls", 32'(n_cls - c0), 32'(0));
    chk("to_done", 32'(n_done - d0), 32'(1));
    chk("to_beats", 32'(out_q.size()), 32'(0));

    // ccl_done on the last allowed cycle wins over the timeout
    do_frame(8'd7, 8'd8, 20, 2, 0, 1, 1, 0, 0, 0, 1);
    chk_order("ccl_edge", 2);
    chk("ccl_edge_to", 32'(err_timeout), 32'(0));

    // Classifier timeout with characters pending still drains them
    do_frame(8'd9, 8'd9, 2, 3, 0, 2, 0, 0, 0, 0, 1);
    chk_order("cls_to", 3);
    chk("cls_to_flag", 32'(err_timeout), 32'(1));

    // Same-cycle valid+done, into an empty and a non-empty buffer
    do_frame(8'd3, 8'd4, 2, 1, 0, 0, 1, 1, 0, 0, 1);
    chk_order("merge1", 1);
    chk("merge1_cnt", 32'(char_cnt), 32'(1));
    do_frame(8'd3, 8'd4, 2, 3, 0, 1, 1, 1, 2, 0, 1);
    chk_order("merge3", 3);

    // start held high while busy is ignored
    d0 = n_done; c0 = n_ccl;
    do_frame(8'd11, 8'd12, 5, 4, 1, 2, 1, 0, 0, 1, 1);
    chk("busy_start_ccl", 32'(n_ccl - c0), 32'(1));
    chk("busy_start_done", 32'(n_done - d0), 32'(1));
    chk_order("busy_start", 4);

    // Reset during DRAIN abandons the frame without done
    do_frame(8'd13, 8'd14, 3, 4, 0, 1, 1, 0, 3, 0, 0);
    tick(); tick();
    d0 = n_done;
    chk("pre_rst_valid", 32'(ch_valid), 32'(1));
    rst = 1'b0; #2;
    chk("rst_valid", 32'(ch_valid), 32'(0));
    chk("rst_data", 32'(ch_data), 32'(0));
    chk("rst_busy2", 32'(busy), 32'(0));
    chk("rst_cnt2", 32'(char_cnt), 32'(0));
    chk("rst_thl", 32'(ccl_th_low), 32'(0));
    repeat (3) tick();
    rst = 1'b1; rdy_mode = 0;
    repeat (5) tick();
    chk("rst_no_done", 32'(n_done - d0), 32'(0));
    do_frame(8'd40, 8'd255, 10, 5, 0, 2, 1, 0, 0, 0, 1);
    chk_order("post_rst", 5);

    // Random frames, stream compared against the model's stored characters
    for (int f = 0; f < 14; f++) begin
      do_frame(PIX_W'($urandom), PIX_W'($urandom), $urandom_range(22, 1),
               $urandom_range(10, 0), $urandom_range(3, 0), $urandom_range(8, 0),
               1'(($urandom % 4) != 0), 1'($urandom % 2), 2, 0, 1);
      chk("rnd_beats", 32'(out_q.size()), 32'(m_q.size()));
      for (int i = 0; i < out_q.size() && i < m_q.size(); i++)
        chk("rnd_order", 32'(out_q[i]), 32'(m_q[i]));
    end

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/lp_plate_seq.md
LP_PLATE_SEQ -- requirements
Module: lp_plate_seq

Parameters
REQ-001 SHALL have parameter ADDR_W, default 16, image address width.
REQ-002 SHALL have parameter PIX_W, default 8, pixel/threshold width.
REQ-003 SHALL have parameter CH_W, default 6, character code width.
REQ-004 SHALL have parameter MAX_CHARS, default 8, character buffer depth (power of 2, >=2).
REQ-005 SHALL have parameter TO_CYCLES, default 65535, per-phase timeout in clk cycles (>=1).

Interface
REQ-006 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-007 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-008 SHALL have ports start in 1 (frame request) and th_low / th_high in PIX_W each (runtime thresholds).
REQ-009 SHALL have ports ccl_start out 1, ccl_th_low / ccl_th_high out PIX_W, ccl_done in 1, and ccl_addr in ADDR_W (labeling engine).
REQ-010 SHALL have ports cls_start out 1, cls_addr in ADDR_W, cls_valid in 1, cls_char in CH_W, cls_ok in 1, and cls_done in 1 (classifier engine).
REQ-011 SHALL have port pix_addr  out  ADDR_W  shared image memory address.
REQ-012 SHALL have ports ch_data out CH_W, ch_valid out 1, ch_last out 1, and ch_ready in 1 (result stream).
REQ-013 SHALL have ports busy out 1, done out 1, char_cnt out clog2(MAX_CHARS)+1, rej_cnt out 8, err_timeout out 1, and err_overflow out 1.

Function
REQ-014 SHALL implement FSM states IDLE, CCL, CLS, DRAIN, FIN.
REQ-015 IDLE: on start=1, SHALL latch th_low/th_high into ccl_th_low/ccl_th_high, clear char_cnt, rej_cnt and both error flags, pulse ccl_start for exactly 1 cycle, and enter CCL next cycle.
REQ-016 SHALL ignore start in every state except IDLE; busy SHALL be 1 in every state except IDLE.
REQ-017 CCL: pix_addr SHALL equal ccl_addr combinationally; on ccl_done=1 SHALL pulse cls_start for 1 cycle and enter CLS.
REQ-018 CLS: pix_addr SHALL equal cls_addr; in all other states pix_addr SHALL be 0.
REQ-019 CLS: cls_valid=1 with cls_ok=1 SHALL write cls_char to the buffer at the next free slot and increment char_cnt, provided the buffer is not full.
REQ-020 CLS: cls_valid=1 with cls_ok=0 SHALL increment rej_cnt, saturating at 255.
REQ-021 cls_valid=1 with cls_ok=1 while the buffer is full SHALL discard the character and set err_overflow, which is sticky until the next accepted start.
REQ-022 cls_valid and cls_done asserted in the same cycle SHALL process the character first and then transition.
REQ-023 On cls_done, SHALL enter DRAIN if char_cnt>0, else enter FIN.
REQ-024 DRAIN: SHALL present characters in write order; ch_valid=1 and ch_data SHALL be held stable until ch_ready=1; ch_last=1 SHALL accompany the final character only.
REQ-025 After the handshake of the ch_last character, SHALL enter FIN; char_cnt SHALL retain the stored count (it is not decremented by draining).
REQ-026 Timeout counter SHALL reload to TO_CYCLES on entry to CCL or CLS and on each cls_valid, and decrement every cycle while in CCL or CLS.
REQ-027 Counter reaching 0 SHALL set err_timeout and enter DRAIN (if char_cnt>0) or FIN; ccl_done/cls_done arriving in the same cycle SHALL take priority over the timeout.
REQ-028 FIN: SHALL pulse done for exactly 1 cycle and return to IDLE next cycle.
REQ-029 ccl_start, cls_start and done SHALL be registered single-cycle pulses.

Reset
REQ-030 rst=0 SHALL, asynchronously, force state IDLE and empty the buffer, and drive all outputs to 0 (pix_addr, ch_data, ccl_th_low/high, counts and flags included).
REQ-031 rst asserted mid-frame SHALL abandon the frame without emitting done; the first start after rst=1 SHALL be accepted normally.

Verification
REQ-032 Nominal: th_low=40, th_high=255; start; ccl_done at +10; classifier sends 7 valid chars, all ok, then cls_done -> 7 ordered stream beats, ch_last on the 7th, char_cnt=7, done pulse, no errors.
REQ-033 Backpressure: ch_ready toggles 1/0 every cycle during DRAIN -> ch_data stable while ch_valid=1 and ch_ready=0; no beat lost or duplicated.
REQ-034 Overflow/reject: 10 ok chars plus 3 cls_ok=0 with MAX_CHARS=8 -> first 8 stored, err_overflow=1, rej_cnt=3, 8 beats output.
REQ-035 Timeout: TO_CYCLES=20, ccl_done never asserted -> err_timeout=1 at cycle 20 of CCL, no cls_start, done pulses, zero stream beats.
REQ-036 Same-cycle events: cls_valid+cls_ok+cls_done in the same cycle -> character stored and emitted; start asserted while busy -> ignored; rst=0 during DRAIN -> all outputs 0, no done pulse.
